// File: rtl/mul_seq_if.sv
// mul_seq_if: request/response handshake and shared EXE adder bus of the sequential multiplier.
//   req_valid/req_ready, req_a, req_b, req_op : operation request (op 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU)
//   rsp_valid/rsp_ready, rsp_data             : result handshake
//   alu_req, alu_control, alu_a, alu_b        : borrowed adder operands (control 00 add, 01 subtract)
//   alu_out                                   : combinational adder result for the same cycle
//   master: requester side (also supplies the adder result); slave: the multiplier.
interface mul_seq_if #(parameter int BITS = 32);
    logic            req_valid;
    logic            req_ready;
    logic [BITS-1:0] req_a;
    logic [BITS-1:0] req_b;
    logic [1:0]      req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] rsp_data;
    logic            alu_req;
    logic [1:0]      alu_control;
    logic [BITS-1:0] alu_a;
    logic [BITS-1:0] alu_b;
    logic [BITS-1:0] alu_out;
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_out,
        input  req_ready, rsp_valid, rsp_data, alu_req, alu_control, alu_a, alu_b
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_out,
        output req_ready, rsp_valid, rsp_data, alu_req, alu_control, alu_a, alu_b
    );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: fixed-latency shift-add multiplier (MUL/MULH/MULHSU/MULHU) that borrows a shared adder.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous abort, returns to IDLE on the next edge and drops any pending response
//   bus   : mul_seq_if slave port (request, response and adder signals)
module mul_seq #(
    parameter int BITS = 32
) (
    input logic     clk,
    input logic     rst_n,
    input logic     flush,
    mul_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, ITER, FIX_LO, FIX_HI, DONE} state_t;
    state_t          state, next;
    logic [4:0]      cnt;
    logic [BITS-1:0] a, b, p_hi, p_lo, sum;
    logic [1:0]      op;
    logic            neg, z, sign_a, sign_b, carry;
    assign sign_a = (op == 2'b01 || op == 2'b10) && a[BITS-1];
    assign sign_b = op == 2'b01 && b[BITS-1];
    // Adder wrap-around detects the carry out of P_HI + |A|; skipped partial products carry nothing.
    assign carry  = p_lo[0] && (bus.alu_out < p_hi);
    assign sum    = p_lo[0] ? bus.alu_out : p_hi;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    always_comb begin
        next            = state;
        bus.req_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_data    = '0;
        bus.alu_req     = 1'b0;
        bus.alu_control = 2'b00;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                next = bus.req_valid ? PREP_A : IDLE;
            end
            PREP_A: begin
                bus.alu_req     = 1'b1;
                bus.alu_control = 2'b01;
                bus.alu_b       = a;
                next            = PREP_B;
            end
            PREP_B: begin
                bus.alu_req     = 1'b1;
                bus.alu_control = 2'b01;
                bus.alu_b       = b;
                next            = ITER;
            end
            ITER: begin
                bus.alu_req = 1'b1;
                bus.alu_a   = p_hi;
                bus.alu_b   = a;
                next        = cnt == 5'(BITS - 1) ? FIX_LO : ITER;
            end
            FIX_LO: begin
                bus.alu_req     = 1'b1;
                bus.alu_control = 2'b01;
                bus.alu_b       = p_lo;
                next            = FIX_HI;
            end
            FIX_HI: begin
                // Two's-complement of the high word: ~hi plus the borrow from a zero low word.
                bus.alu_req = 1'b1;
                bus.alu_a   = ~p_hi;
                bus.alu_b   = BITS'(z);
                next        = DONE;
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = op == 2'b00 ? p_lo : p_hi;
                next          = bus.rsp_ready ? IDLE : DONE;
            end
            default: next = IDLE;
        endcase
        if (flush) next = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            a    <= '0;
            b    <= '0;
            op   <= '0;
            p_hi <= '0;
            p_lo <= '0;
            neg  <= 1'b0;
            z    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && !flush) begin
                    a   <= bus.req_a;
                    b   <= bus.req_b;
                    op  <= bus.req_op;
                    cnt <= '0;
                end
                PREP_A: begin
                    if (sign_a) a <= bus.alu_out;
                    neg <= sign_a;
                end
                PREP_B: begin
                    p_hi <= '0;
                    p_lo <= sign_b ? bus.alu_out : b;
                    neg  <= neg ^ sign_b;
                end
                ITER: begin
                    {p_hi, p_lo} <= {carry, sum, p_lo[BITS-1:1]};
                    cnt <= cnt + 5'd1;
                end
                FIX_LO: if (neg) begin
                    p_lo <= bus.alu_out;
                    z    <= p_lo == '0;
                end
                FIX_HI: if (neg) p_hi <= bus.alu_out;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: table-driven and scoreboard checks of mul_seq with a modelled shared adder.
module tb_mul_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mul_seq_if #(.BITS(32)) bus();
    mul_seq #(.BITS(32)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

    assign bus.alu_out = bus.alu_control == 2'b01 ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] pa, pb, p;
        pa = {{34{a[31] & (op == 2'b01 || op == 2'b10)}}, a};
        pb = {{34{b[31] & (op == 2'b01)}}, b};
        p  = pa * pb;
        return op == 2'b00 ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 100);
    endtask

    task automatic quiet(input int cycles, input string name);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        check({name, " no response"}, seen, 0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold, input string name);
        int n;
        logic [31:0] e;
        exp_q.push_back(exp);
        start(op, a, b);
        wait_rsp(n);
        check({name, " latency"}, n, 37);
        repeat (hold) begin
            check({name, " held data"}, bus.rsp_data, exp_q[0]);
            check({name, " held ready/valid/alu_req"}, {bus.req_ready, bus.rsp_valid, bus.alu_req}, 3'b010);
            @(negedge clk);
        end
        e = exp_q.pop_front();
        check({name, " data"}, bus.rsp_data, e);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check({name, " idle after rsp"}, {bus.req_ready, bus.rsp_valid, bus.rsp_data}, {2'b10, 32'h0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b0;
        vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu max"});
        vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, "mul -1x2"});
        vecs.push_back('{2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, "mul 3x5"});
        vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh min*min"});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulh -1x2"});
        vecs.push_back('{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu -1xmax"});
        vecs.push_back('{2'b10, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, "mulhsu z path"});
        vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mulhsu min*max"});
        vecs.push_back('{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, "mulh -3x5"});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh -1x-1"});
        vecs.push_back('{2'b11, 32'h80000000, 32'h00000002, 32'h00000001, "mulhu 2^31x2"});
        vecs.push_back('{2'b00, 32'h12345678, 32'h00000010, 32'h23456780, "mul shift"});

        #12;
        check("reset handshake", {bus.req_ready, bus.rsp_valid, bus.alu_req, bus.alu_control}, 5'b10000);
        check("reset alu operands", {bus.alu_a, bus.alu_b}, 64'h0);
        check("reset rsp_data", bus.rsp_data, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, vecs[i].name);
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            do_op(rop, ra, rb, ref_mul(rop, ra, rb), 0, "random");
        end

        do_op(2'b00, 32'd3, 32'd5, 32'h0000000F, 10, "hold");

        bus.req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush beats accept", {bus.req_ready, bus.alu_req}, 2'b10);

        start(2'b11, 32'hFFFFFFFF, 32'h12345678);
        @(negedge clk);
        check("prep_a alu", {bus.alu_req, bus.alu_control, bus.alu_a, bus.alu_b}, {1'b1, 2'b01, 32'h0, 32'hFFFFFFFF});
        repeat (12) @(negedge clk);
        check("iter alu", {bus.alu_req, bus.alu_control}, 3'b100);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("after flush", {bus.req_ready, bus.rsp_valid, bus.alu_req}, 3'b100);
        quiet(50, "flush");
        do_op(2'b00, 32'd7, 32'd6, 32'h0000002A, 0, "after flush mul");

        start(2'b01, 32'h80000000, 32'h00000003);
        repeat (23) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset", {bus.req_ready, bus.rsp_valid, bus.alu_req, bus.alu_control}, 5'b10000);
        check("async reset alu", {bus.alu_a, bus.alu_b}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("after reset", {bus.req_ready, bus.rsp_valid, bus.alu_req}, 3'b100);
        quiet(50, "reset");
        do_op(2'b00, 32'd7, 32'd6, 32'h0000002A, 0, "after reset mul");

        start(2'b00, 32'd9, 32'd9);
        wait_rsp(n);
        check("done flush latency", n, 37);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("done flush discards", {bus.req_ready, bus.rsp_valid, bus.rsp_data}, {2'b10, 32'h0});

        check("scoreboard empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter BITS, default 32, operand/result width; only 32 is verified.
REQ-002 SHALL have port CLK, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port FLUSH, input, 1, synchronous abort of the current operation.
REQ-005 SHALL have ports REQ_VALID input 1 and REQ_READY output 1, the request handshake.
REQ-006 SHALL have ports REQ_A and REQ_B, input, BITS, multiplicand and multiplier.
REQ-007 SHALL have port REQ_OP, input, 2: 00 MUL (low word), 01 MULH (signed×signed), 10 MULHSU (signed A × unsigned B), 11 MULHU (unsigned×unsigned).
REQ-008 SHALL have ports RSP_VALID output 1, RSP_READY input 1, and RSP_DATA output BITS, the response handshake.
REQ-009 SHALL have port ALU_REQ, output, 1, high while the sequencer owns the shared EXE adder.
REQ-010 SHALL have ports ALU_CONTROL output 2, and ALU_A and ALU_B output BITS; ALU_CONTROL 00 = A+B, 01 = A−B.
REQ-011 SHALL have port ALU_OUT, input, BITS, the combinational adder result for the same cycle.

Function
REQ-012 SHALL implement states IDLE, PREP_A, PREP_B, ITER, FIX_LO, FIX_HI and DONE, traversed in that order.
REQ-013 SHALL drive REQ_READY=1 only in IDLE; accept on REQ_VALID&&REQ_READY&&!FLUSH, latch operands and op, then go to PREP_A.
REQ-014 SHALL, in PREP_A, drive ALU_A=0, ALU_B=A, ALU_CONTROL=01, and latch |A| when A is treated as signed and A[31]=1; otherwise keep A.
REQ-015 SHALL apply the same rule to B in PREP_B; B is treated as signed only for MULH.
REQ-016 SHALL latch neg = signA^signB, where each sign is 0 for an operand treated as unsigned; the magnitude of 0x80000000 is 0x80000000 taken as unsigned.
REQ-017 SHALL run ITER for exactly BITS cycles using a 5-bit counter starting at 0 and leaving ITER after count 31.
REQ-018 SHALL, per ITER cycle, drive ALU_A=P_HI, ALU_B=|A| and ALU_CONTROL=00.
REQ-019 SHALL derive carry = (ALU_OUT < P_HI) unsigned, and use sum=ALU_OUT when P_LO[0]=1, else sum=P_HI with carry=0.
REQ-020 SHALL update {P_HI,P_LO} <= {carry,sum,P_LO[31:1]} each ITER cycle; P_HI=0 and P_LO=|B| on entry to ITER.
REQ-021 SHALL, in FIX_LO when neg=1, drive ALU_A=0, ALU_B=P_LO, ALU_CONTROL=01, and latch P_LO<=ALU_OUT and z=(P_LO==0).
REQ-022 SHALL, in FIX_HI when neg=1, drive ALU_A=~P_HI, ALU_B=z, ALU_CONTROL=00, and latch P_HI<=ALU_OUT.
REQ-023 SHALL leave registers unchanged in FIX_LO/FIX_HI when neg=0, with the states still consumed, giving fixed latency.
REQ-024 SHALL assert RSP_VALID first in the 37th cycle after the accept edge, as an exact count.
REQ-025 SHALL, in DONE, drive RSP_VALID=1 with RSP_DATA=P_LO for MUL and P_HI otherwise.
REQ-026 SHALL hold RSP_VALID and RSP_DATA stable until RSP_READY=1, then return to IDLE on that edge.
REQ-027 SHALL take no new request in the DONE→IDLE cycle; REQ_READY rises the following cycle.
REQ-028 SHALL drive ALU_REQ=1 only in PREP_A..FIX_HI; when ALU_REQ=0, ALU_CONTROL, ALU_A and ALU_B SHALL all be 0.
REQ-029 SHALL treat FLUSH=1 in any state as forcing IDLE next edge; a pending response is discarded and FLUSH wins over a simultaneous accept.
REQ-030 SHALL drive RSP_DATA=0 whenever RSP_VALID=0.

Reset
REQ-031 SHALL, while RST_N=0, immediately force state IDLE, counter 0, P_HI/P_LO/operands/neg/z 0, REQ_READY=1, RSP_VALID=0, RSP_DATA=0, ALU_REQ=0 and ALU outputs 0.
REQ-032 SHALL abandon an operation hit by reset mid-flight, producing no response after release.

Verification
REQ-033 SHALL cover: MULHU 0xFFFFFFFF×0xFFFFFFFF -> RSP_DATA=0xFFFFFFFE, RSP_VALID exactly 37 cycles after accept.
REQ-034 SHALL cover: MUL 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFE; MUL 3×5 -> 0x0000000F.
REQ-035 SHALL cover: MULH 0x80000000×0x80000000 -> 0x40000000; MULH 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
REQ-036 SHALL cover: MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MULHSU 0xFFFFFFFF×0 -> 0x00000000 (z path).
REQ-037 SHALL cover: RSP_READY low 10 cycles in DONE -> RSP_VALID/RSP_DATA held, REQ_READY=0 and ALU_REQ=0 throughout.
REQ-038 SHALL cover: FLUSH at ITER count 10, and RST_N low at ITER count 20 -> next cycle IDLE, REQ_READY=1, no RSP_VALID, and a following MUL 7×6 -> 0x0000002A.
